// File: rtl/imem_boot_loader.sv
// UART boot loader: frames SYNC,N,4*N bytes into 32-bit words for the instruction memory, then releases the core.
// Latency: one WRITE cycle per word after its 4th byte; no backpressure, a byte is taken on every rx_valid strobe.
module imem_boot_loader #(
    parameter int unsigned DEPTH   = 14,
    parameter logic [7:0]  SYNC    = 8'hA5,
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        reload,
    input  logic [31:0] pc,
    output logic [31:0] imem_A,
    output logic        imem_WE,
    output logic [31:0] imem_WD,
    output logic        core_rst,
    output logic        loading,
    output logic        done,
    output logic        err,
    output logic [3:0]  words_loaded
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_SYNC, S_COUNT, S_BYTES, S_WRITE, S_RUN} state_t;

    state_t        state, state_nxt;
    logic [3:0]    idx;
    logic [3:0]    n_words;
    logic [1:0]    byte_cnt;
    logic [23:0]   asm_dat;
    logic [TW-1:0] timer;
    logic          tmo;
    logic          cnt_ok;
    logic          err_nxt;
    logic          done_nxt;

    assign tmo    = (timer == TW'(TIMEOUT - 1)) && !rx_valid;
    assign cnt_ok = (rx_data != 8'd0) && (rx_data <= 8'(DEPTH));

    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        done_nxt  = 1'b0;
        if (reload) begin
            state_nxt = S_SYNC;
        end else begin
            case (state)
                S_SYNC: begin
                    if (rx_valid && rx_data == SYNC) state_nxt = S_COUNT;
                end
                S_COUNT: begin
                    if (rx_valid) begin
                        if (cnt_ok) begin
                            state_nxt = S_BYTES;
                        end else begin
                            state_nxt = S_SYNC;
                            err_nxt   = 1'b1;
                        end
                    end else if (tmo) begin
                        state_nxt = S_SYNC;
                        err_nxt   = 1'b1;
                    end
                end
                S_BYTES: begin
                    if (rx_valid && byte_cnt == 2'd3) begin
                        state_nxt = S_WRITE;
                    end else if (tmo) begin
                        state_nxt = S_SYNC;
                        err_nxt   = 1'b1;
                    end
                end
                S_WRITE: begin
                    // WRITE is always entered right after a byte, so the timer cannot expire here
                    if (idx == n_words - 4'd1) begin
                        state_nxt = S_RUN;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = S_BYTES;
                    end
                end
                S_RUN: state_nxt = S_RUN;
                default: state_nxt = S_SYNC;
            endcase
        end
    end

    assign imem_WE  = (state == S_WRITE) && !RST && !reload;
    assign imem_A   = (state == S_RUN) ? pc : {26'd0, idx, 2'b00};
    assign core_rst = (state != S_RUN);
    assign loading  = (state != S_RUN);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= S_SYNC;
            idx          <= '0;
            n_words      <= '0;
            byte_cnt     <= '0;
            asm_dat      <= '0;
            timer        <= '0;
            imem_WD      <= '0;
            words_loaded <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            err   <= err_nxt;
            timer <= (rx_valid || state_nxt == S_SYNC || state_nxt == S_RUN) ? '0 : timer + 1'b1;
            if (reload) begin
                idx      <= '0;
                byte_cnt <= '0;
            end else begin
                case (state)
                    S_SYNC: begin
                        if (rx_valid && rx_data == SYNC) begin
                            idx          <= '0;
                            byte_cnt     <= '0;
                            words_loaded <= '0;
                        end
                    end
                    S_COUNT: begin
                        if (rx_valid) n_words <= rx_data[3:0];
                    end
                    S_BYTES: begin
                        if (rx_valid) begin
                            asm_dat  <= {rx_data, asm_dat[23:8]};
                            byte_cnt <= byte_cnt + 2'd1;
                            if (byte_cnt == 2'd3) imem_WD <= {rx_data, asm_dat};
                        end
                    end
                    S_WRITE: begin
                        words_loaded <= idx + 4'd1;
                        if (idx != n_words - 4'd1) idx <= idx + 4'd1;
                        // a byte arriving during the write starts the next word
                        if (rx_valid) begin
                            asm_dat  <= {rx_data, asm_dat[23:8]};
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader; short TIMEOUT keeps the idle test brief.
module tb_imem_boot_loader;

    localparam int TMO = 40;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        reload = 1'b0;
    logic [31:0] pc = 32'hDEADBEEF;
    logic [31:0] imem_A;
    logic        imem_WE;
    logic [31:0] imem_WD;
    logic        core_rst;
    logic        loading;
    logic        done;
    logic        err;
    logic [3:0]  words_loaded;

    imem_boot_loader #(.DEPTH(14), .SYNC(8'hA5), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST(RST), .rx_valid(rx_valid), .rx_data(rx_data),
        .reload(reload), .pc(pc), .imem_A(imem_A), .imem_WE(imem_WE),
        .imem_WD(imem_WD), .core_rst(core_rst), .loading(loading),
        .done(done), .err(err), .words_loaded(words_loaded)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    logic [31:0] wr_a[$];
    logic [31:0] wr_d[$];

    always @(negedge CLK) begin
        if (imem_WE) begin
            wr_a.push_back(imem_A);
            wr_d.push_back(imem_WD);
        end
        if (done) done_cnt++;
        if (err) err_cnt++;
    end

    task automatic clear_log();
        wr_a.delete();
        wr_d.delete();
        done_cnt = 0;
        err_cnt = 0;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge CLK); #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(posedge CLK); #1;
        reload = 1'b0;
    endtask

    function automatic logic [31:0] wa(input int k);
        return (k < wr_a.size()) ? wr_a[k] : 32'hxxxxxxxx;
    endfunction

    function automatic logic [31:0] wd(input int k);
        return (k < wr_d.size()) ? wr_d[k] : 32'hxxxxxxxx;
    endfunction

    task automatic test_reset();
        RST = 1'b1;
        idle(3);
        checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL reset_core_rst got %b want 1", core_rst); end
        checks++; if (loading !== 1'b1) begin errors++; $display("FAIL reset_loading got %b want 1", loading); end
        checks++; if (imem_WE !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", imem_WE); end
        checks++; if (imem_WD !== 32'h0) begin errors++; $display("FAIL reset_wd got %h want 0", imem_WD); end
        checks++; if (imem_A !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", imem_A); end
        checks++; if ({done, err} !== 2'b00) begin errors++; $display("FAIL reset_pulses got %b want 00", {done, err}); end
        checks++; if (words_loaded !== 4'd0) begin errors++; $display("FAIL reset_words got %0d want 0", words_loaded); end
        RST = 1'b0;
        idle(1);
    endtask

    task automatic test_single();
        clear_log();
        send(8'hA5); send(8'h01); send(8'h93); send(8'h00); send(8'h10); send(8'h00);
        idle(3);
        pc = 32'h4; #1;
        checks++; if (wr_a.size() !== 1) begin errors++; $display("FAIL single_nwr got %0d want 1", wr_a.size()); end
        checks++; if (wa(0) !== 32'h0) begin errors++; $display("FAIL single_addr got %h want 0", wa(0)); end
        checks++; if (wd(0) !== 32'h00100093) begin errors++; $display("FAIL single_data got %h want 00100093", wd(0)); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL single_done got %0d want 1", done_cnt); end
        checks++; if (core_rst !== 1'b0) begin errors++; $display("FAIL single_core_rst got %b want 0", core_rst); end
        checks++; if (loading !== 1'b0) begin errors++; $display("FAIL single_loading got %b want 0", loading); end
        checks++; if (imem_A !== 32'h4) begin errors++; $display("FAIL single_pc_fwd got %h want 4", imem_A); end
        checks++; if (words_loaded !== 4'd1) begin errors++; $display("FAIL single_words got %0d want 1", words_loaded); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  b;
        logic [31:0] exp;
        do_reload();
        clear_log();
        send(8'hA5); send(8'h0E);
        for (int k = 0; k < 14; k++)
            for (int j = 0; j < 4; j++) begin
                b = 8'(4 * k + j + 64);
                send(b);
            end
        idle(3);
        checks++; if (wr_a.size() !== 14) begin errors++; $display("FAIL full_nwr got %0d want 14", wr_a.size()); end
        for (int k = 0; k < 14; k++) begin
            exp = {8'(4 * k + 67), 8'(4 * k + 66), 8'(4 * k + 65), 8'(4 * k + 64)};
            checks++; if (wa(k) !== 32'(4 * k)) begin errors++; $display("FAIL full_addr[%0d] got %h want %h", k, wa(k), 32'(4 * k)); end
            checks++; if (wd(k) !== exp) begin errors++; $display("FAIL full_data[%0d] got %h want %h", k, wd(k), exp); end
        end
        checks++; if (words_loaded !== 4'd14) begin errors++; $display("FAIL full_words got %0d want 14", words_loaded); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL full_done got %0d want 1", done_cnt); end
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL full_err got %0d want 0", err_cnt); end
    endtask

    task automatic test_bad_count();
        do_reload();
        clear_log();
        send(8'hA5); send(8'h0F);
        idle(2);
        checks++; if (err_cnt !== 1) begin errors++; $display("FAIL badcnt15_err got %0d want 1", err_cnt); end
        checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL badcnt_core_rst got %b want 1", core_rst); end
        send(8'hA5); send(8'h00);
        idle(2);
        checks++; if (err_cnt !== 2) begin errors++; $display("FAIL badcnt0_err got %0d want 2", err_cnt); end
        checks++; if (wr_a.size() !== 0) begin errors++; $display("FAIL badcnt_nwr got %0d want 0", wr_a.size()); end
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL badcnt_done got %0d want 0", done_cnt); end
        checks++; if (words_loaded !== 4'd0) begin errors++; $display("FAIL badcnt_words got %0d want 0", words_loaded); end
    endtask

    task automatic test_junk();
        clear_log();
        send(8'h11); send(8'h22); send(8'hA5); send(8'h02);
        for (int i = 0; i < 8; i++) send(8'(16 + i));
        idle(3);
        checks++; if (wr_a.size() !== 2) begin errors++; $display("FAIL junk_nwr got %0d want 2", wr_a.size()); end
        checks++; if (wa(0) !== 32'h0 || wa(1) !== 32'h4) begin errors++; $display("FAIL junk_addr got %h,%h want 0,4", wa(0), wa(1)); end
        checks++; if (wd(0) !== 32'h13121110) begin errors++; $display("FAIL junk_data0 got %h want 13121110", wd(0)); end
        checks++; if (wd(1) !== 32'h17161514) begin errors++; $display("FAIL junk_data1 got %h want 17161514", wd(1)); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL junk_done got %0d want 1", done_cnt); end
    endtask

    task automatic test_timeout();
        do_reload();
        clear_log();
        send(8'hA5); send(8'h02);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h05);
        idle(TMO - 5);
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL tmo_early_err got %0d want 0", err_cnt); end
        idle(10);
        checks++; if (err_cnt !== 1) begin errors++; $display("FAIL tmo_err got %0d want 1", err_cnt); end
        checks++; if (wr_a.size() !== 1) begin errors++; $display("FAIL tmo_nwr got %0d want 1", wr_a.size()); end
        checks++; if (wd(0) !== 32'h04030201) begin errors++; $display("FAIL tmo_data got %h want 04030201", wd(0)); end
        checks++; if (core_rst !== 1'b1 || done_cnt !== 0) begin errors++; $display("FAIL tmo_state got core_rst=%b done=%0d want 1,0", core_rst, done_cnt); end
        checks++; if (words_loaded !== 4'd1) begin errors++; $display("FAIL tmo_words got %0d want 1", words_loaded); end
        clear_log();
        send(8'hA5); send(8'h01); send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        idle(3);
        checks++; if (wr_a.size() !== 1 || wd(0) !== 32'hDDCCBBAA) begin errors++; $display("FAIL tmo_reload_data got n=%0d %h want 1 DDCCBBAA", wr_a.size(), wd(0)); end
        checks++; if (done_cnt !== 1 || err_cnt !== 0) begin errors++; $display("FAIL tmo_reload_pulses got done=%0d err=%0d want 1,0", done_cnt, err_cnt); end
    endtask

    task automatic test_reload_collision();
        reload   = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        @(posedge CLK); #1;
        reload   = 1'b0;
        rx_valid = 1'b0;
        checks++; if (core_rst !== 1'b1 || loading !== 1'b1) begin errors++; $display("FAIL reload_core_rst got %b%b want 11", core_rst, loading); end
        clear_log();
        send(8'h01); send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
        idle(3);
        checks++; if (wr_a.size() !== 0) begin errors++; $display("FAIL reload_dropped got nwr=%0d want 0", wr_a.size()); end
        send(8'hA5); send(8'h01); send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        idle(3);
        checks++; if (wa(0) !== 32'h0 || wd(0) !== 32'hDEADBEEF) begin errors++; $display("FAIL reload_word got %h@%h want DEADBEEF@0", wd(0), wa(0)); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL reload_done got %0d want 1", done_cnt); end
    endtask

    task automatic test_rst_mid_write();
        do_reload();
        clear_log();
        send(8'hA5); send(8'h01); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        idle(2);
        checks++; if (wr_a.size() !== 0) begin errors++; $display("FAIL rstwr_nwr got %0d want 0", wr_a.size()); end
        checks++; if (core_rst !== 1'b1 || done_cnt !== 0) begin errors++; $display("FAIL rstwr_state got core_rst=%b done=%0d want 1,0", core_rst, done_cnt); end
        checks++; if (words_loaded !== 4'd0 || imem_WD !== 32'h0) begin errors++; $display("FAIL rstwr_regs got words=%0d wd=%h want 0,0", words_loaded, imem_WD); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_bad_count();
        test_junk();
        test_timeout();
        test_reload_collision();
        test_rst_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
